// File: rtl/tensor_core_sequencer.sv
// tensor_core_sequencer
// Runs one tensor-core job end to end: loads matrix A (slot 0) and matrix B
// (slot 1) through the register file's single-element write port, fires a
// programmable number of bulk writes (A <= A*B), snapshots slot 0 and streams
// the 16 result elements out on a valid/ready port.
//
// Ports:
//   clock_in, reset_in                      clock, synchronous active-high reset
//   start_in, repeat_count_in               job request and bulk-write count
//   in_valid_in, in_data_in, in_ready_out   operand stream (A then B, row-major)
//   tensor_core_matrix_in                   register file slot 0 read data
//   non_bulk_write_*_out                    single-element write controls
//   bulk_write_enable_out                   bulk write strobe
//   out_valid_out, out_data_out, out_ready_in  result stream (row-major)
//   busy_out, done_out                      job status
module tensor_core_sequencer #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned REPEAT_WIDTH  = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                               clock_in,
  input  logic                               reset_in,
  input  logic                               start_in,
  input  logic [REPEAT_WIDTH-1:0]            repeat_count_in,
  input  logic                               in_valid_in,
  input  logic [DATA_WIDTH-1:0]              in_data_in,
  output logic                               in_ready_out,
  input  logic [3:0][3:0][DATA_WIDTH-1:0]    tensor_core_matrix_in,
  output logic                               non_bulk_write_enable_out,
  output logic [4:0]                         non_bulk_write_register_address_out,
  output logic [DATA_WIDTH-1:0]              non_bulk_write_data_out,
  output logic                               bulk_write_enable_out,
  output logic                               out_valid_out,
  output logic [DATA_WIDTH-1:0]              out_data_out,
  input  logic                               out_ready_in,
  output logic                               busy_out,
  output logic                               done_out
);

  localparam int unsigned OPERAND_COUNT = 32;
  localparam int unsigned RESULT_COUNT  = 16;
  localparam int unsigned SETTLE_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [4:0] LOAD_LAST  = 5'(OPERAND_COUNT - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(RESULT_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_SETTLE,
    S_DRAIN
  } state_t;

  state_t                               state;
  logic [4:0]                           load_idx;
  logic [REPEAT_WIDTH-1:0]              repeat_q;
  logic [REPEAT_WIDTH-1:0]              bulk_cnt;
  logic [SETTLE_W-1:0]                  settle_cnt;
  logic [3:0]                           drain_idx;
  // Flat view of slot 0; element r*4+c matches the packed [r][c] layout.
  logic [RESULT_COUNT-1:0][DATA_WIDTH-1:0] snapshot;

  logic in_accept;
  logic out_accept;

  // Handshake readiness is a pure state decode so the first LOAD/DRAIN cycle is usable.
  assign in_ready_out  = (state == S_LOAD);
  assign out_valid_out = (state == S_DRAIN);
  assign in_accept     = in_valid_in & in_ready_out;
  assign out_accept    = out_valid_out & out_ready_in;

  // Job sequencer: state, counters, snapshot and all registered outputs.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state                               <= S_IDLE;
      load_idx                            <= '0;
      repeat_q                            <= '0;
      bulk_cnt                            <= '0;
      settle_cnt                          <= '0;
      drain_idx                           <= '0;
      snapshot                            <= '0;
      non_bulk_write_enable_out           <= 1'b0;
      non_bulk_write_register_address_out <= '0;
      non_bulk_write_data_out             <= '0;
      bulk_write_enable_out               <= 1'b0;
      out_data_out                        <= '0;
      busy_out                            <= 1'b0;
      done_out                            <= 1'b0;
    end else begin
      // Strobes and the completion flag are single-cycle pulses.
      non_bulk_write_enable_out <= 1'b0;
      bulk_write_enable_out     <= 1'b0;
      done_out                  <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (start_in) begin
            repeat_q <= repeat_count_in;
            load_idx <= '0;
            busy_out <= 1'b1;
            state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          // Index doubles as the register address: bit 4 picks slot B after 16 bytes.
          if (in_accept) begin
            non_bulk_write_enable_out           <= 1'b1;
            non_bulk_write_register_address_out <= load_idx;
            non_bulk_write_data_out             <= in_data_in;
            load_idx                            <= load_idx + 5'd1;
            if (load_idx == LOAD_LAST) begin
              bulk_cnt <= '0;
              state    <= S_COMPUTE;
            end
          end
        end

        S_COMPUTE: begin
          // The last non-bulk strobe is visible during the first COMPUTE cycle,
          // so bulk strobes scheduled from here never overlap it.
          if (bulk_cnt != repeat_q) begin
            bulk_write_enable_out <= 1'b1;
            bulk_cnt              <= bulk_cnt + REPEAT_WIDTH'(1);
          end else begin
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            snapshot     <= tensor_core_matrix_in;
            out_data_out <= tensor_core_matrix_in[0][0];
            drain_idx    <= '0;
            state        <= S_DRAIN;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
        end

        S_DRAIN: begin
          // out_data_out only changes on a handshake, so it holds under backpressure.
          if (out_accept) begin
            if (drain_idx == DRAIN_LAST) begin
              out_data_out <= '0;
              busy_out     <= 1'b0;
              done_out     <= 1'b1;
              state        <= S_IDLE;
            end else begin
              drain_idx    <= drain_idx + 4'd1;
              out_data_out <= snapshot[drain_idx + 4'd1];
            end
          end
        end

        default: begin
          busy_out <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_core_sequencer.sv
// Directed bench for tensor_core_sequencer with a behavioural register file
// (slot 0 = A, slot 1 = B, bulk write A <= A*B mod 256).
module tb_tensor_core_sequencer;

  logic                  clk = 1'b0;
  logic                  reset_in;
  logic                  start_in;
  logic [3:0]            repeat_count_in;
  logic                  in_valid_in;
  logic [7:0]            in_data_in;
  logic                  in_ready_out;
  logic [3:0][3:0][7:0]  tcm;
  logic                  nb_we;
  logic [4:0]            nb_addr;
  logic [7:0]            nb_data;
  logic                  bulk_we;
  logic                  out_valid_out;
  logic [7:0]            out_data_out;
  logic                  out_ready_in;
  logic                  busy_out;
  logic                  done_out;

  always #5 clk = ~clk;

  tensor_core_sequencer #(
    .DATA_WIDTH   (8),
    .REPEAT_WIDTH (4),
    .SETTLE_CYCLES(1)
  ) dut (
    .clock_in                           (clk),
    .reset_in                           (reset_in),
    .start_in                           (start_in),
    .repeat_count_in                    (repeat_count_in),
    .in_valid_in                        (in_valid_in),
    .in_data_in                         (in_data_in),
    .in_ready_out                       (in_ready_out),
    .tensor_core_matrix_in              (tcm),
    .non_bulk_write_enable_out          (nb_we),
    .non_bulk_write_register_address_out(nb_addr),
    .non_bulk_write_data_out            (nb_data),
    .bulk_write_enable_out              (bulk_we),
    .out_valid_out                      (out_valid_out),
    .out_data_out                       (out_data_out),
    .out_ready_in                       (out_ready_in),
    .busy_out                           (busy_out),
    .done_out                           (done_out)
  );

  // Behavioural register file
  logic [7:0] rf_a [16];
  logic [7:0] rf_b [16];

  function automatic logic [7:0] mm(input int r, input int c);
    logic [7:0] s;
    s = 8'd0;
    for (int k = 0; k < 4; k++) s = 8'(s + rf_a[r*4+k] * rf_b[k*4+c]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (nb_we) begin
      if (nb_addr[4]) rf_b[nb_addr[3:0]] <= nb_data;
      else            rf_a[nb_addr[3:0]] <= nb_data;
    end
    if (bulk_we)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          rf_a[r*4+c] <= mm(r, c);
  end

  always_comb begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        tcm[r][c] = rf_a[r*4+c];
  end

  // Cycle counter and event logs
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nb_addr_q[$];
  int nb_cyc_q[$];
  int bulk_cyc_q[$];
  int hold_q[$];
  int both_cnt;
  int done_cnt;
  int first_valid_cyc;

  always @(negedge clk) begin
    if (nb_we) begin
      nb_addr_q.push_back(int'(nb_addr));
      nb_cyc_q.push_back(cyc);
    end
    if (bulk_we) bulk_cyc_q.push_back(cyc);
    if (nb_we && bulk_we) both_cnt++;
    if (done_out) done_cnt++;
    if (out_valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;
  end

  int pass_cnt = 0;
  int check_cnt = 0;
  int c0;
  bit feed_timeout;
  bit drain_timeout;
  logic done_first;
  logic busy_first;
  logic [7:0] opa [16];
  logic [7:0] opb [16];
  logic [7:0] res [16];

  // Stimulus helpers
  task automatic clear_logs();
    @(posedge clk);
    nb_addr_q.delete();
    nb_cyc_q.delete();
    bulk_cyc_q.delete();
    both_cnt        = 0;
    done_cnt        = 0;
    first_valid_cyc = -1;
    feed_timeout    = 1'b0;
    drain_timeout   = 1'b0;
  endtask

  task automatic begin_job(input logic [3:0] r);
    clear_logs();
    @(negedge clk);
    start_in        = 1'b1;
    repeat_count_in = r;
    c0              = cyc;
  endtask

  task automatic feed(input bit alt, input int limit);
    int i;
    int guard;
    bit skip;
    i = 0; guard = 0; skip = 1'b0;
    while (i < limit && guard < 400) begin
      @(negedge clk);
      guard++;
      start_in = 1'b0;
      if (alt && skip) begin
        in_valid_in = 1'b0;
      end else begin
        in_valid_in = 1'b1;
        in_data_in  = (i < 16) ? opa[i] : opb[i-16];
      end
      if (alt) skip = ~skip;
      if (in_valid_in && in_ready_out) i++;
    end
    if (i < limit) feed_timeout = 1'b1;
  endtask

  task automatic drain(input int stall_k, input int stall_len, input int start_k);
    int k;
    int guard;
    int stalled;
    k = 0; guard = 0; stalled = 0;
    hold_q.delete();
    while (k < 16 && guard < 600) begin
      @(negedge clk);
      guard++;
      in_valid_in  = 1'b0;
      start_in     = 1'b0;
      out_ready_in = 1'b1;
      if (out_valid_out && k == stall_k && stalled < stall_len) begin
        out_ready_in = 1'b0;
        stalled++;
        hold_q.push_back(int'(out_data_out));
      end
      if (out_valid_out && k == start_k && out_ready_in) start_in = 1'b1;
      if (out_valid_out && out_ready_in) begin
        res[k] = out_data_out;
        k++;
      end
    end
    if (k < 16) drain_timeout = 1'b1;
    @(negedge clk);
    start_in     = 1'b0;
    out_ready_in = 1'b1;
    done_first   = done_out;
    busy_first   = busy_out;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Tests
  task automatic test_reset();
    logic [25:0] all_out;
    reset_in = 1'b1;
    idle(2);
    all_out = {in_ready_out, nb_we, nb_addr, nb_data, bulk_we, out_valid_out,
               out_data_out, busy_out, done_out};
    check_cnt++;
    if (all_out !== 26'd0) $display("FAIL reset_outputs: got %h want 0", all_out);
    else pass_cnt++;
    reset_in    = 1'b0;
    in_valid_in = 1'b1;
    in_data_in  = 8'hAA;
    idle(3);
    check_cnt++;
    if ({in_ready_out, nb_we, busy_out} !== 3'b000)
      $display("FAIL idle_ignores_valid: ready/we/busy=%b want 000", {in_ready_out, nb_we, busy_out});
    else pass_cnt++;
    in_valid_in = 1'b0;
  endtask

  task automatic test_identity();
    for (int i = 0; i < 16; i++) begin
      opa[i] = (i % 5 == 0) ? 8'd1 : 8'd0;
      opb[i] = 8'(i + 1);
    end
    begin_job(4'd1);
    feed(1'b0, 32);
    drain(-1, 0, -1);
    idle(3);
    check_cnt++;
    if (feed_timeout || drain_timeout) $display("FAIL ident_timeout: feed=%0b drain=%0b want 0/0", feed_timeout, drain_timeout);
    else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      check_cnt++;
      if (res[k] !== 8'(k + 1)) $display("FAIL ident_res[%0d]: got %0d want %0d", k, res[k], k + 1);
      else pass_cnt++;
    end
    check_cnt++;
    if (first_valid_cyc - c0 != 36) $display("FAIL ident_first_valid: got cycle %0d want 36", first_valid_cyc - c0);
    else pass_cnt++;
    check_cnt++;
    if (nb_cyc_q.size() != 32 || nb_cyc_q[0] - c0 != 2 || nb_cyc_q[31] - c0 != 33)
      $display("FAIL ident_nb_strobes: count %0d first %0d last %0d want 32/2/33",
               nb_cyc_q.size(), nb_cyc_q.size() > 0 ? nb_cyc_q[0] - c0 : -1,
               nb_cyc_q.size() > 31 ? nb_cyc_q[31] - c0 : -1);
    else pass_cnt++;
    check_cnt++;
    if (bulk_cyc_q.size() != 1 || bulk_cyc_q[0] - c0 != 34)
      $display("FAIL ident_bulk: count %0d first %0d want 1 at 34", bulk_cyc_q.size(),
               bulk_cyc_q.size() > 0 ? bulk_cyc_q[0] - c0 : -1);
    else pass_cnt++;
    check_cnt++;
    if (both_cnt != 0) $display("FAIL ident_overlap: got %0d want 0", both_cnt);
    else pass_cnt++;
    check_cnt++;
    if (done_first !== 1'b1 || busy_first !== 1'b0 || done_cnt != 1)
      $display("FAIL ident_done: done=%b busy=%b pulses=%0d want 1/0/1", done_first, busy_first, done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_no_repeat();
    for (int i = 0; i < 16; i++) begin
      opa[i] = 8'(8'h10 + i);
      opb[i] = 8'(8'hF0 - i);
    end
    begin_job(4'd0);
    feed(1'b0, 32);
    drain(-1, 0, -1);
    idle(2);
    check_cnt++;
    if (bulk_cyc_q.size() != 0 || drain_timeout) $display("FAIL r0_bulk: got %0d strobes want 0", bulk_cyc_q.size());
    else pass_cnt++;
    check_cnt++;
    if (first_valid_cyc - c0 != 35) $display("FAIL r0_first_valid: got cycle %0d want 35", first_valid_cyc - c0);
    else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      check_cnt++;
      if (res[k] !== 8'(8'h10 + k)) $display("FAIL r0_res[%0d]: got %h want %h", k, res[k], 8'(8'h10 + k));
      else pass_cnt++;
    end
  endtask

  task automatic test_repeat_two();
    for (int i = 0; i < 16; i++) begin
      opa[i] = (i % 5 == 0) ? 8'd1 : 8'd0;
      opb[i] = (i % 5 == 0) ? 8'd2 : 8'd0;
    end
    begin_job(4'd2);
    feed(1'b0, 32);
    drain(-1, 0, -1);
    idle(2);
    check_cnt++;
    if (bulk_cyc_q.size() != 2 || bulk_cyc_q[0] - c0 != 34 || bulk_cyc_q[1] - c0 != 35)
      $display("FAIL r2_bulk: count %0d want 2 at cycles 34,35", bulk_cyc_q.size());
    else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      check_cnt++;
      if (res[k] !== ((k % 5 == 0) ? 8'd4 : 8'd0))
        $display("FAIL r2_res[%0d]: got %0d want %0d", k, res[k], (k % 5 == 0) ? 4 : 0);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    bit order_ok;
    bit hold_ok;
    for (int i = 0; i < 16; i++) begin
      opa[i] = (i % 5 == 0) ? 8'd1 : 8'd0;
      opb[i] = 8'(8'h20 + i);
    end
    begin_job(4'd1);
    feed(1'b1, 32);
    drain(3, 5, -1);
    idle(2);
    order_ok = (nb_addr_q.size() == 32);
    for (int i = 0; i < nb_addr_q.size() && i < 32; i++) if (nb_addr_q[i] != i) order_ok = 1'b0;
    check_cnt++;
    if (!order_ok || feed_timeout) $display("FAIL bp_addr_order: %0d writes, not 0..31 in order", nb_addr_q.size());
    else pass_cnt++;
    hold_ok = (hold_q.size() == 5);
    foreach (hold_q[i]) if (hold_q[i] != 8'h23) hold_ok = 1'b0;
    check_cnt++;
    if (!hold_ok) $display("FAIL bp_hold: %0d stalled samples, first %h, want 5 of 23",
                           hold_q.size(), hold_q.size() > 0 ? hold_q[0] : -1);
    else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      check_cnt++;
      if (res[k] !== 8'(8'h20 + k)) $display("FAIL bp_res[%0d]: got %h want %h", k, res[k], 8'(8'h20 + k));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midjob();
    logic [25:0] all_out;
    bit order_ok;
    for (int i = 0; i < 16; i++) begin
      opa[i] = (i % 5 == 0) ? 8'd1 : 8'd0;
      opb[i] = 8'(8'h30 + i);
    end
    begin_job(4'd1);
    feed(1'b0, 10);
    @(negedge clk);
    reset_in    = 1'b1;
    in_valid_in = 1'b0;
    @(negedge clk);
    all_out = {in_ready_out, nb_we, nb_addr, nb_data, bulk_we, out_valid_out,
               out_data_out, busy_out, done_out};
    check_cnt++;
    if (all_out !== 26'd0) $display("FAIL midreset_outputs: got %h want 0", all_out);
    else pass_cnt++;
    reset_in = 1'b0;
    idle(2);
    for (int i = 0; i < 16; i++) opb[i] = 8'(8'h40 + i);
    begin_job(4'd1);
    feed(1'b0, 32);
    drain(-1, 0, -1);
    idle(2);
    order_ok = (nb_addr_q.size() == 32);
    for (int i = 0; i < nb_addr_q.size() && i < 32; i++) if (nb_addr_q[i] != i) order_ok = 1'b0;
    check_cnt++;
    if (!order_ok) $display("FAIL midreset_reload: %0d writes, not 0..31 in order", nb_addr_q.size());
    else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      check_cnt++;
      if (res[k] !== 8'(8'h40 + k)) $display("FAIL midreset_res[%0d]: got %h want %h", k, res[k], 8'(8'h40 + k));
      else pass_cnt++;
    end
  endtask

  task automatic test_start_in_drain();
    for (int i = 0; i < 16; i++) begin
      opa[i] = 8'h10;
      opb[i] = 8'h10;
    end
    begin_job(4'd1);
    feed(1'b0, 32);
    drain(-1, 0, 5);
    idle(4);
    for (int k = 0; k < 16; k++) begin
      check_cnt++;
      if (res[k] !== 8'h00) $display("FAIL wrap_res[%0d]: got %h want 00", k, res[k]);
      else pass_cnt++;
    end
    check_cnt++;
    if (busy_out !== 1'b0 || in_ready_out !== 1'b0 || done_cnt != 1)
      $display("FAIL drain_start_ignored: busy=%b ready=%b done_pulses=%0d want 0/0/1",
               busy_out, in_ready_out, done_cnt);
    else pass_cnt++;
  endtask

  initial begin
    reset_in        = 1'b1;
    start_in        = 1'b0;
    repeat_count_in = 4'd0;
    in_valid_in     = 1'b0;
    in_data_in      = 8'd0;
    out_ready_in    = 1'b1;
    both_cnt        = 0;
    done_cnt        = 0;
    first_valid_cyc = -1;
    test_reset();
    test_identity();
    test_no_repeat();
    test_repeat_two();
    test_backpressure();
    test_reset_midjob();
    test_start_in_drain();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
